// File: rtl/snoop_memory_controller_pkg.sv
// ------------------------------------------------------------------------
// snoop_pkg : shared constants, field positions and helpers for the MSI
//             snoop bus memory controller.                   Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package snoop_pkg;

  localparam int NUM_NODES = 4;
  localparam int WORD_W    = 12;
  localparam int DATA_W    = 8;
  localparam int PROC_W    = 2;
  localparam int CMD_W     = 3;
  localparam int TAG_W     = 5;
  localparam int SNOOP_W   = NUM_NODES * WORD_W;

  localparam int WB_BIT    = 11;
  localparam int HIT_BIT   = 10;
  localparam int STATE_MSB = 9;
  localparam int STATE_LSB = 8;

  localparam logic [1:0] ST_INVALID  = 2'b00;
  localparam logic [1:0] ST_SHARED   = 2'b01;
  localparam logic [1:0] ST_MODIFIED = 2'b10;

  localparam logic [CMD_W-1:0] CMD_NONE    = 3'b000;
  localparam logic [CMD_W-1:0] CMD_RD_MISS = 3'b001;
  localparam logic [CMD_W-1:0] CMD_WR_MISS = 3'b010;
  localparam logic [CMD_W-1:0] CMD_INV     = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SNOOP = 2'd1,
    S_WB    = 2'd2,
    S_DONE  = 2'd3
  } ctrl_state_t;

  function automatic logic [WORD_W-1:0] pack_resp(
    input logic              wb_seen,
    input logic              data_valid,
    input logic [1:0]        grant_state,
    input logic [DATA_W-1:0] data
  );
    return {wb_seen, data_valid, grant_state, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/snoop_memory_controller_if.sv
// ------------------------------------------------------------------------
// snoop_memory_controller_if : request, snoop and response bundle.
//                                                            Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface snoop_memory_controller_if;
  import snoop_pkg::*;

  logic                  req_valid;
  logic [PROC_W-1:0]     req_proc;
  logic [CMD_W-1:0]      req_cmd;
  logic [TAG_W-1:0]      req_tag;
  logic [SNOOP_W-1:0]    snoop_in;
  logic [WORD_W-1:0]     resp_out;
  logic                  resp_valid;
  logic                  busy;

  modport master (
    output req_valid, req_proc, req_cmd, req_tag, snoop_in,
    input  resp_out, resp_valid, busy
  );

  modport slave (
    input  req_valid, req_proc, req_cmd, req_tag, snoop_in,
    output resp_out, resp_valid, busy
  );

endinterface

`default_nettype wire

// File: rtl/snoop_memory_controller_priority_select.sv
// ------------------------------------------------------------------------
// snoop_priority_select : picks the fill supplier and write-back source
//                         from the four snoop words.         Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module snoop_priority_select
  import snoop_pkg::*;
(
  input  logic [SNOOP_W-1:0] snoop_in,
  input  logic [PROC_W-1:0]  req_proc,
  output logic               any_hit,
  output logic [DATA_W-1:0]  supplier_data,
  output logic               wb_seen,
  output logic [DATA_W-1:0]  wb_data
);

  logic [NUM_NODES-1:0] hit_vec;
  logic [NUM_NODES-1:0] mod_vec;
  logic [DATA_W-1:0]    data_arr [NUM_NODES];

  for (genvar p = 0; p < NUM_NODES; p++) begin : g_word
    logic [WORD_W-1:0] word;
    logic [1:0]        st;
    logic              other;
    assign word        = snoop_in[p*WORD_W +: WORD_W];
    assign st          = word[STATE_MSB:STATE_LSB];
    assign other       = (req_proc != PROC_W'(p));
    assign data_arr[p] = word[DATA_W-1:0];
    // state 11 is neither shared nor modified, so it never counts as a hit
    assign hit_vec[p]  = other && word[HIT_BIT] && (st == ST_SHARED || st == ST_MODIFIED);
    assign mod_vec[p]  = other && word[WB_BIT] && (st == ST_MODIFIED);
  end

  always_comb begin
    any_hit       = 1'b0;
    supplier_data = '0;
    wb_seen       = 1'b0;
    wb_data       = '0;
    // walk downwards so the lowest index is the last to win
    for (int p = NUM_NODES - 1; p >= 0; p--) begin
      if (hit_vec[p]) begin
        any_hit       = 1'b1;
        supplier_data = data_arr[p];
      end
      if (mod_vec[p]) begin
        wb_seen = 1'b1;
        wb_data = data_arr[p];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/snoop_memory_controller.sv
// ------------------------------------------------------------------------
// snoop_memory_controller : shared-memory responder for the 4-node MSI
//                           snooping bus.                    Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module snoop_memory_controller
  import snoop_pkg::*;
#(
  parameter int SNOOP_CYCLES = 1,
  parameter int MEM_DEPTH    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  snoop_memory_controller_if.slave  bus
);

  localparam int               MEM_BITS = MEM_DEPTH * DATA_W;
  localparam logic [1:0]       LAST_CNT = 2'(SNOOP_CYCLES - 1);

  function automatic logic [MEM_BITS-1:0] mem_init();
    logic [MEM_BITS-1:0] v;
    v = '0;
    for (int a = 0; a < MEM_DEPTH; a++) begin
      v[a*DATA_W +: DATA_W] = DATA_W'(3 * a);
    end
    return v;
  endfunction

  ctrl_state_t          state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [PROC_W-1:0]    proc_q, proc_d;
  logic [CMD_W-1:0]     cmd_q, cmd_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 any_hit_q, any_hit_d;
  logic [DATA_W-1:0]    sup_data_q, sup_data_d;
  logic                 wb_seen_q, wb_seen_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;
  logic [WORD_W-1:0]    resp_out_q, resp_out_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 busy_q, busy_d;
  // memory has no reset: its power-up image is the only initial content
  logic [MEM_BITS-1:0]  mem_q = mem_init();
  logic [MEM_BITS-1:0]  mem_d;

  logic                 sel_any_hit;
  logic [DATA_W-1:0]    sel_supplier_data;
  logic                 sel_wb_seen;
  logic [DATA_W-1:0]    sel_wb_data;
  logic [$clog2(MEM_BITS)-1:0] mem_base;
  logic [DATA_W-1:0]    mem_rd;
  logic [DATA_W-1:0]    fill_data;
  logic [WORD_W-1:0]    resp_word;
  logic                 do_wb;

  snoop_priority_select u_select (
    .snoop_in      (bus.snoop_in),
    .req_proc      (proc_q),
    .any_hit       (sel_any_hit),
    .supplier_data (sel_supplier_data),
    .wb_seen       (sel_wb_seen),
    .wb_data       (sel_wb_data)
  );

  assign mem_base  = {tag_q, 3'b000};
  assign mem_rd    = mem_q[mem_base +: DATA_W];
  assign fill_data = any_hit_q ? sup_data_q : mem_rd;

  always_comb begin
    resp_word = '0;
    do_wb     = 1'b0;
    case (cmd_q)
      CMD_RD_MISS: begin
        resp_word = pack_resp(wb_seen_q, 1'b1, ST_SHARED, fill_data);
        do_wb     = wb_seen_q;
      end
      CMD_WR_MISS: begin
        resp_word = pack_resp(wb_seen_q, 1'b1, ST_MODIFIED, fill_data);
        do_wb     = wb_seen_q;
      end
      CMD_INV: begin
        resp_word = pack_resp(wb_seen_q, 1'b0, ST_MODIFIED, '0);
        do_wb     = wb_seen_q;
      end
      CMD_NONE: resp_word = '0;
      default:  resp_word = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    proc_d       = proc_q;
    cmd_d        = cmd_q;
    tag_d        = tag_q;
    any_hit_d    = any_hit_q;
    sup_data_d   = sup_data_q;
    wb_seen_d    = wb_seen_q;
    wb_data_d    = wb_data_q;
    resp_out_d   = resp_out_q;
    resp_valid_d = resp_valid_q;
    busy_d       = busy_q;
    mem_d        = mem_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          proc_d  = bus.req_proc;
          cmd_d   = bus.req_cmd;
          tag_d   = bus.req_tag;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SNOOP;
        end
      end
      S_SNOOP: begin
        if (cnt_q == LAST_CNT) begin
          any_hit_d  = sel_any_hit;
          sup_data_d = sel_supplier_data;
          wb_seen_d  = sel_wb_seen;
          wb_data_d  = sel_wb_data;
          state_d    = S_WB;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WB: begin
        resp_out_d   = resp_word;
        resp_valid_d = 1'b1;
        if (do_wb) begin
          mem_d[mem_base +: DATA_W] = wb_data_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        resp_valid_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      proc_q       <= '0;
      cmd_q        <= '0;
      tag_q        <= '0;
      any_hit_q    <= 1'b0;
      sup_data_q   <= '0;
      wb_seen_q    <= 1'b0;
      wb_data_q    <= '0;
      resp_out_q   <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      proc_q       <= proc_d;
      cmd_q        <= cmd_d;
      tag_q        <= tag_d;
      any_hit_q    <= any_hit_d;
      sup_data_q   <= sup_data_d;
      wb_seen_q    <= wb_seen_d;
      wb_data_q    <= wb_data_d;
      resp_out_q   <= resp_out_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  // a reset coinciding with the WB edge abandons the pending write-back
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  assign bus.resp_out   = resp_out_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_snoop_memory_controller.sv
// ------------------------------------------------------------------------
// tb_snoop_memory_controller : directed and randomized checks of the
//                              snoop memory controller.      Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_snoop_memory_controller;

  localparam int SC = 1;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [7:0] model_mem [32];

  snoop_memory_controller_if bus ();

  snoop_memory_controller #(
    .SNOOP_CYCLES (SC),
    .MEM_DEPTH    (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic wb, input logic hit, input logic [1:0] st,
                                     input logic [7:0] d);
    return {wb, hit, st, d};
  endfunction

  // Reference: what the memory side should answer, from the bus rules alone.
  function automatic logic [11:0] model_resp(input logic [1:0] p, input logic [2:0] c,
                                             input logic [4:0] t, input logic [47:0] s,
                                             output bit do_wb, output logic [7:0] wb_val);
    logic [11:0] w;
    bit          found;
    bit          wbs;
    logic [7:0]  fill;
    found  = 0;
    wbs    = 0;
    fill   = model_mem[t];
    wb_val = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (i == int'(p)) continue;
      w = s[12*i +: 12];
      if (!found && w[10] && (w[9:8] == 2'b01 || w[9:8] == 2'b10)) begin
        found = 1;
        fill  = w[7:0];
      end
      if (!wbs && w[11] && w[9:8] == 2'b10) begin
        wbs    = 1;
        wb_val = w[7:0];
      end
    end
    case (c)
      3'b001:  begin do_wb = wbs; return {wbs, 1'b1, 2'b01, fill}; end
      3'b010:  begin do_wb = wbs; return {wbs, 1'b1, 2'b10, fill}; end
      3'b011:  begin do_wb = wbs; return {wbs, 1'b0, 2'b10, 8'h00}; end
      default: begin do_wb = 0;   return 12'h000; end
    endcase
  endfunction

  // Called #1 after an edge with the controller idle.
  task automatic run_txn(input string nm, input logic [1:0] p, input logic [2:0] c,
                         input logic [4:0] t, input logic [47:0] s, input bit extra_pulse,
                         output logic [11:0] got);
    logic [11:0] exp;
    bit          do_wb;
    logic [7:0]  wb_val;
    exp = model_resp(p, c, t, s, do_wb, wb_val);
    bus.req_valid = 1'b1;
    bus.req_proc  = p;
    bus.req_cmd   = c;
    bus.req_tag   = t;
    bus.snoop_in  = s;
    @(posedge clock); #1;
    bus.req_valid = extra_pulse;
    check({nm, "_busy_accept"}, 32'(bus.busy), 32'd1);
    for (int k = 1; k <= SC; k++) begin
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      check({nm, "_no_early_valid"}, 32'(bus.resp_valid), 32'd0);
    end
    @(posedge clock); #1;
    got = bus.resp_out;
    check({nm, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({nm, "_resp_out"}, 32'(bus.resp_out), 32'(exp));
    check({nm, "_busy_resp"}, 32'(bus.busy), 32'd1);
    if (do_wb) model_mem[t] = wb_val;
    @(posedge clock); #1;
    check({nm, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
    check({nm, "_busy_drop"}, 32'(bus.busy), 32'd0);
    check({nm, "_resp_hold"}, 32'(bus.resp_out), 32'(exp));
  endtask

  initial begin
    logic [11:0] got;
    logic [47:0] s;
    logic [2:0]  c;
    n_cmp = 0;
    n_err = 0;
    for (int a = 0; a < 32; a++) model_mem[a] = 8'(3 * a);
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_proc  = 2'd0;
    bus.req_cmd   = 3'd0;
    bus.req_tag   = 5'd0;
    bus.snoop_in  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_resp_out", 32'(bus.resp_out), 32'd0);
    check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_txn("rd_nohit", 2'd0, 3'b001, 5'd7, 48'h0, 0, got);
    check("rd_nohit_const", 32'(got), 32'h515);

    run_txn("rd_wb", 2'd1, 3'b001, 5'd12, {36'h0, mk(1, 1, 2'b10, 8'd55)}, 0, got);
    check("rd_wb_const", 32'(got), 32'hD37);
    run_txn("rd_after_wb", 2'd0, 3'b001, 5'd12, 48'h0, 0, got);
    check("mem12_written", 32'(got), 32'h537);

    run_txn("wr_shared", 2'd2, 3'b010, 5'd14,
            {mk(0, 1, 2'b01, 8'd50), 24'h0, mk(0, 1, 2'b01, 8'd50)}, 0, got);
    check("wr_shared_const", 32'(got), 32'h632);
    run_txn("mem14_keep", 2'd0, 3'b001, 5'd14, 48'h0, 0, got);
    check("mem14_keep_const", 32'(got), 32'h52A);

    s = {24'h0, mk(0, 1, 2'b01, 8'd90), 12'h0};
    run_txn("inv", 2'd3, 3'b011, 5'd18, s, 0, got);
    check("inv_const", 32'(got), 32'h200);
    run_txn("reserved", 2'd3, 3'b111, 5'd18, s, 0, got);
    check("reserved_const", 32'(got), 32'h000);
    run_txn("mem18_keep", 2'd0, 3'b001, 5'd18, 48'h0, 0, got);
    check("mem18_keep_const", 32'(got), 32'h536);

    run_txn("self_excl", 2'd2, 3'b001, 5'd5, {12'h0, mk(1, 1, 2'b10, 8'd99), 24'h0}, 1, got);
    check("self_excl_const", 32'(got), 32'h50F);
    repeat (2) begin
      @(posedge clock); #1;
      check("ignored_pulse_valid", 32'(bus.resp_valid), 32'd0);
      check("ignored_pulse_busy", 32'(bus.busy), 32'd0);
    end

    // abort with a write-back pending to tag 12
    bus.req_valid = 1'b1;
    bus.req_proc  = 2'd1;
    bus.req_cmd   = 3'b001;
    bus.req_tag   = 5'd12;
    bus.snoop_in  = {36'h0, mk(1, 1, 2'b10, 8'd77)};
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    repeat (SC) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("abort_resp_out", 32'(bus.resp_out), 32'd0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_no_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clock); #1;
    run_txn("after_abort", 2'd0, 3'b001, 5'd12, 48'h0, 0, got);
    check("mem12_after_abort", 32'(got), 32'h537);

    for (int n = 0; n < 40; n++) begin
      s = {$urandom, $urandom};
      c = 3'($urandom_range(0, 7));
      if (c == 3'b000 || c[2]) s = s & ~48'h800_800_800_800;
      run_txn("rand", 2'($urandom_range(0, 3)), c, 5'($urandom_range(0, 31)), s, 0, got);
    end
    for (int a = 0; a < 32; a++) begin
      run_txn("final_mem", 2'd0, 3'b001, 5'(a), 48'h0, 0, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
